face_dispatch_ctrl: RTL and testbench
=====================================

# face_dispatch_ctrl

Parametrised face-fetch and triangle-dispatch controller for the rendering pipeline. It sits between the face SRAM, the vertice shader and the rasterizer. It walks face indices 0..num_of_faces-1, reads each face's three vertex indices and sends them to the shader with a valid/ready handshake. It then assembles the returned transformed vertices into triangles and queues them in a TRI_DEPTH-deep buffer, so SRAM/shader work overlaps rasterization. Compared with the previous controller it adds a configurable SRAM latency, a triangle buffer, tag-based vertex reassembly, degenerate-face culling and a defined finish/drain rule.

## Interface
Parameters:
- ADDR_W, 20, width of SRAM face address and of vertex index
- FCNT_W, 21, width of num_of_faces
- X_W / Y_W, 12 / 12, screen coordinate widths
- Z_W, 21, depth width
- C_W, 24, color width (RGB888)
- SRAM_LAT, 3, cycles from sram_rd_en to face_v* valid (≥1)
- TRI_DEPTH, 4, triangle buffer entries (power of 2, ≥2)

Derived: V_W = X_W+Y_W+Z_W+C_W; TRI_W = 3*V_W.

Ports:
- clk  in  1  clock, all logic on rising edge
- srst  in  1  synchronous reset, active-high
- enable  in  1  start pulse, sampled only in IDLE
- cull_en  in  1  drop faces with two equal vertex indices; sampled at start
- num_of_faces  in  FCNT_W  face count; sampled at start
- sram_rd_en  out  1  face read strobe
- sram_addr  out  ADDR_W  face index being read
- face_v1/v2/v3  in  ADDR_W each  vertex indices, valid SRAM_LAT cycles after sram_rd_en
- shd_valid  out  1  vertex index offered to shader
- shd_ready  in  1  shader accepts
- shd_vidx  out  ADDR_W  vertex index
- shd_tag  out  2  slot 0/1/2 in triangle
- vtx_valid  in  1  transformed vertex returned (no backpressure)
- vtx_tag  in  2  slot of returned vertex
- vtx_data  in  V_W  {x, y, depth, color}, x at MSB
- tri_valid  out  1  buffer head valid
- tri_ready  in  1  rasterizer pops
- tri_data  out  TRI_W  {v1, v2, v3}, v1 at MSB
- busy  out  1  high from start until finish
- finish  out  1  one-cycle pulse when the job completes
- culled_cnt  out  FCNT_W  faces dropped in the current job

## Operation
- States: IDLE, FETCH, WAIT_SRAM, ISSUE, COLLECT, PUSH, DONE.
- IDLE: on enable, latch num_of_faces and cull_en, clear face_idx and culled_cnt, and set busy. If num_of_faces==0, go to DONE; otherwise go to FETCH.
- FETCH: entered only when buffer occupancy + 1 ≤ TRI_DEPTH; otherwise stall in FETCH. Pulse sram_rd_en for one cycle with sram_addr=face_idx, then go to WAIT_SRAM.
- WAIT_SRAM: count SRAM_LAT cycles, then capture face_v1..3.
  - If cull_en and any pair of indices is equal: increment culled_cnt and go to the next-face step.
  - Otherwise go to ISSUE.
- ISSUE: offer slots 0, 1, 2 in order. A slot advances on shd_valid&&shd_ready. After slot 2 is accepted, go to COLLECT.
- COLLECT: store each vtx_valid beat in slot vtx_tag; returns may arrive in any order, including during ISSUE. When all three slot flags are set, go to PUSH.
- PUSH: write the assembled triangle into the buffer, then take the next-face step.
- Next-face step: face_idx+1. If face_idx+1 == num_of_faces, go to DONE; otherwise go to FETCH.
- DONE: wait until the buffer is empty, then pulse finish, clear busy and go to IDLE.
- Buffer behaviour:
  - Circular FIFO.
  - A push and a pop in the same cycle leave occupancy unchanged.
  - A pop when empty is ignored.
  - A push is never attempted when full (guaranteed by the FETCH check).
- Duplicate vtx_tag within one face: the later beat overwrites the earlier one.
- enable outside IDLE is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, buffer empty. Reset mid-job aborts the job and discards buffered triangles.
- All outputs are registered. tri_data/tri_valid come from the buffer head register and present a new head the cycle after a pop.
- Unstalled minimum per face: 1 (FETCH) + SRAM_LAT + 3 (ISSUE) + COLLECT wait + 1 (PUSH).
- tri_valid rises one cycle after PUSH.
- Handshakes:
  - shd_vidx/shd_tag are held stable while shd_valid && !shd_ready.
  - tri_data is held stable while tri_valid && !tri_ready.
- finish rises one cycle after the buffer becomes empty in DONE. With num_of_faces==0 this is 2 cycles after enable.

## Structure
- Package dispatch_pkg holds:
  - the state enum;
  - the field offsets of x/y/depth/color inside a vertex word;
  - the V_W/TRI_W helper functions.
- Sub-module tri_fifo (parametrised TRI_W, TRI_DEPTH) implements the triangle buffer, with push, pop, full, empty and count outputs.

## Test plan
- num_of_faces=1, faces {5,9,2}, shd_ready=1, in-order returns -> shd_vidx sequence 5,9,2; one tri_valid carrying those three vertex words; finish pulses once; culled_cnt=0.
- num_of_faces=8, tri_ready=0 -> exactly 4 triangles buffered and sram_rd_en stops; releasing tri_ready delivers all 8 in face order; then finish.
- Shader returns tags 2,0,1 with distinct data -> tri_data slots match the tags, not the arrival order.
- cull_en=1, faces {1,1,3},{4,5,6} -> one triangle emitted; culled_cnt=1; finish.
- num_of_faces=0 -> no sram_rd_en; finish pulses 2 cycles after enable.
- srst asserted mid-COLLECT with 2 triangles buffered -> next cycle all outputs are 0 and tri_valid=0; a fresh enable restarts at sram_addr=0.

Source files
------------

// File: rtl/dispatch_pkg.sv
// Shared types and helpers for the face dispatch controller.
// Holds the FSM state enum, vertex-word field offsets and width helpers.
package dispatch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_SRAM,
    S_ISSUE,
    S_COLLECT,
    S_PUSH,
    S_DONE
  } state_e;

  function automatic int calc_vw(int xw, int yw, int zw, int cw);
    return xw + yw + zw + cw;
  endfunction

  function automatic int calc_triw(int vw);
    return 3 * vw;
  endfunction

  // LSB positions of each field inside {x, y, depth, color}
  function automatic int x_off(int yw, int zw, int cw);
    return yw + zw + cw;
  endfunction

  function automatic int y_off(int zw, int cw);
    return zw + cw;
  endfunction

  function automatic int z_off(int cw);
    return cw;
  endfunction

  function automatic int c_off();
    return 0;
  endfunction

endpackage

// File: rtl/tri_fifo.sv
// Circular triangle buffer between dispatch and the rasterizer.
// Ports: push_i/data_i write, pop_i read, data_o head, full/empty/count.
module tri_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          srst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  // Head forced to zero when empty so the output is clean after reset
  assign data_o  = empty_o ? '0 : mem_q[rp_q];

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wp_q <= wp_q + AW'(1);
      if (pop_ok)  rp_q <= rp_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wp_q] <= data_i;
  end

endmodule

// File: rtl/face_dispatch_ctrl.sv
// Face fetch / vertex issue / triangle assembly controller.
// Ports: enable/num_of_faces/cull_en start, sram_* face read, shd_* issue,
// vtx_* return, tri_* buffered triangles, busy/finish/culled_cnt status.
module face_dispatch_ctrl
  import dispatch_pkg::*;
#(
  parameter  int ADDR_W    = 20,
  parameter  int FCNT_W    = 21,
  parameter  int X_W       = 12,
  parameter  int Y_W       = 12,
  parameter  int Z_W       = 21,
  parameter  int C_W       = 24,
  parameter  int SRAM_LAT  = 3,
  parameter  int TRI_DEPTH = 4,
  localparam int V_W       = calc_vw(X_W, Y_W, Z_W, C_W),
  localparam int TRI_W     = calc_triw(V_W)
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              enable,
  input  logic              cull_en,
  input  logic [FCNT_W-1:0] num_of_faces,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [ADDR_W-1:0] face_v1,
  input  logic [ADDR_W-1:0] face_v2,
  input  logic [ADDR_W-1:0] face_v3,
  output logic              shd_valid,
  input  logic              shd_ready,
  output logic [ADDR_W-1:0] shd_vidx,
  output logic [1:0]        shd_tag,
  input  logic              vtx_valid,
  input  logic [1:0]        vtx_tag,
  input  logic [V_W-1:0]    vtx_data,
  output logic              tri_valid,
  input  logic              tri_ready,
  output logic [TRI_W-1:0]  tri_data,
  output logic              busy,
  output logic              finish,
  output logic [FCNT_W-1:0] culled_cnt
);

  localparam int WC_W  = $clog2(SRAM_LAT + 1);
  localparam int CNT_W = $clog2(TRI_DEPTH) + 1;

  state_e                state_q, state_d;
  logic [FCNT_W-1:0]     nf_q, nf_d, idx_q, idx_d;
  logic [FCNT_W-1:0]     cul_q, cul_d;
  logic                  cen_q, cen_d;
  logic [WC_W-1:0]       wc_q, wc_d;
  logic [ADDR_W-1:0]     v2_q, v2_d, v3_q, v3_d;
  logic [2:0][V_W-1:0]   slot_q, slot_d;
  logic [2:0]            flag_q, flag_d;
  logic                  rd_q, rd_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  sv_q, sv_d;
  logic [ADDR_W-1:0]     vidx_q, vidx_d;
  logic [1:0]            tag_q, tag_d;
  logic                  busy_q, busy_d;
  logic                  fin_q, fin_d;

  logic                  push, full, empty;
  logic [CNT_W-1:0]      count;
  logic [FCNT_W-1:0]     idx_nx;
  logic                  last, dup, lat_hit, acc, fetch_ok;

  assign idx_nx   = idx_q + FCNT_W'(1);
  assign last     = (idx_nx == nf_q);
  assign dup      = (face_v1 == face_v2) || (face_v1 == face_v3) ||
                    (face_v2 == face_v3);
  assign lat_hit  = (wc_q == WC_W'(SRAM_LAT));
  assign acc      = sv_q && shd_ready;
  // Only one face is ever in flight, so one free entry is enough
  assign fetch_ok = (count < CNT_W'(TRI_DEPTH));
  assign push     = (state_q == S_PUSH) && !full;

  tri_fifo #(
    .W     (TRI_W),
    .DEPTH (TRI_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .srst_i  (srst),
    .push_i  (push),
    .pop_i   (tri_ready),
    .data_i  ({slot_q[0], slot_q[1], slot_q[2]}),
    .data_o  (tri_data),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_ff @(posedge clk) begin
    if (srst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (enable) state_d = (num_of_faces == '0) ? S_DONE : S_FETCH;
      S_FETCH:
        if (fetch_ok) state_d = S_WAIT_SRAM;
      S_WAIT_SRAM:
        if (lat_hit) begin
          if (cen_q && dup) state_d = last ? S_DONE : S_FETCH;
          else              state_d = S_ISSUE;
        end
      S_ISSUE:
        if (acc && tag_q == 2'd2) state_d = S_COLLECT;
      S_COLLECT:
        if (&flag_q) state_d = S_PUSH;
      S_PUSH:
        state_d = last ? S_DONE : S_FETCH;
      S_DONE:
        if (empty) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    nf_d   = nf_q;
    idx_d  = idx_q;
    cul_d  = cul_q;
    cen_d  = cen_q;
    wc_d   = wc_q;
    v2_d   = v2_q;
    v3_d   = v3_q;
    slot_d = slot_q;
    flag_d = flag_q;
    rd_d   = 1'b0;
    addr_d = addr_q;
    sv_d   = sv_q;
    vidx_d = vidx_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    fin_d  = 1'b0;
    // Returns land by tag in any state; a repeated tag overwrites
    if (vtx_valid && vtx_tag != 2'd3) begin
      flag_d[vtx_tag] = 1'b1;
      slot_d[vtx_tag] = vtx_data;
    end
    unique case (state_q)
      S_IDLE:
        if (enable) begin
          nf_d   = num_of_faces;
          cen_d  = cull_en;
          idx_d  = '0;
          cul_d  = '0;
          busy_d = 1'b1;
        end
      S_FETCH: begin
        wc_d = '0;
        if (fetch_ok) begin
          rd_d   = 1'b1;
          addr_d = ADDR_W'(idx_q);
        end
      end
      S_WAIT_SRAM: begin
        wc_d = wc_q + WC_W'(1);
        if (lat_hit) begin
          v2_d = face_v2;
          v3_d = face_v3;
          if (cen_q && dup) begin
            cul_d = cul_q + FCNT_W'(1);
            idx_d = idx_nx;
          end else begin
            sv_d   = 1'b1;
            vidx_d = face_v1;
            tag_d  = 2'd0;
          end
        end
      end
      S_ISSUE:
        if (acc) begin
          if (tag_q == 2'd2) begin
            sv_d = 1'b0;
          end else begin
            tag_d  = tag_q + 2'd1;
            vidx_d = (tag_q == 2'd0) ? v2_q : v3_q;
          end
        end
      S_PUSH: begin
        flag_d = '0;
        idx_d  = idx_nx;
      end
      S_DONE:
        if (empty) begin
          fin_d  = 1'b1;
          busy_d = 1'b0;
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      nf_q   <= '0;
      idx_q  <= '0;
      cul_q  <= '0;
      cen_q  <= 1'b0;
      wc_q   <= '0;
      v2_q   <= '0;
      v3_q   <= '0;
      slot_q <= '0;
      flag_q <= '0;
      rd_q   <= 1'b0;
      addr_q <= '0;
      sv_q   <= 1'b0;
      vidx_q <= '0;
      tag_q  <= '0;
      busy_q <= 1'b0;
      fin_q  <= 1'b0;
    end else begin
      nf_q   <= nf_d;
      idx_q  <= idx_d;
      cul_q  <= cul_d;
      cen_q  <= cen_d;
      wc_q   <= wc_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      slot_q <= slot_d;
      flag_q <= flag_d;
      rd_q   <= rd_d;
      addr_q <= addr_d;
      sv_q   <= sv_d;
      vidx_q <= vidx_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
      fin_q  <= fin_d;
    end
  end

  assign sram_rd_en = rd_q;
  assign sram_addr  = addr_q;
  assign shd_valid  = sv_q;
  assign shd_vidx   = vidx_q;
  assign shd_tag    = tag_q;
  assign tri_valid  = !empty;
  assign busy       = busy_q;
  assign finish     = fin_q;
  assign culled_cnt = cul_q;

endmodule

// File: tb/tb_face_dispatch_ctrl.sv
// Bench for face_dispatch_ctrl: SRAM, shader and rasterizer models
// plus a triangle/issue scoreboard built from the face table.
module tb_face_dispatch_ctrl;

  localparam int AW  = 20;
  localparam int FW  = 21;
  localparam int VW  = 69;
  localparam int TW  = 207;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic          enable = 1'b0;
  logic          cull_en = 1'b0;
  logic [FW-1:0] num_of_faces = '0;
  logic          sram_rd_en;
  logic [AW-1:0] sram_addr;
  logic [AW-1:0] face_v1 = '0, face_v2 = '0, face_v3 = '0;
  logic          shd_valid;
  logic          shd_ready = 1'b0;
  logic [AW-1:0] shd_vidx;
  logic [1:0]    shd_tag;
  logic          vtx_valid = 1'b0;
  logic [1:0]    vtx_tag = '0;
  logic [VW-1:0] vtx_data = '0;
  logic          tri_valid;
  logic          tri_ready = 1'b0;
  logic [TW-1:0] tri_data;
  logic          busy, finish;
  logic [FW-1:0] culled_cnt;

  always #5 clk = ~clk;

  face_dispatch_ctrl #(.SRAM_LAT(LAT), .TRI_DEPTH(4)) dut (
    .clk(clk), .srst(srst), .enable(enable), .cull_en(cull_en),
    .num_of_faces(num_of_faces),
    .sram_rd_en(sram_rd_en), .sram_addr(sram_addr),
    .face_v1(face_v1), .face_v2(face_v2), .face_v3(face_v3),
    .shd_valid(shd_valid), .shd_ready(shd_ready),
    .shd_vidx(shd_vidx), .shd_tag(shd_tag),
    .vtx_valid(vtx_valid), .vtx_tag(vtx_tag), .vtx_data(vtx_data),
    .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_data(tri_data),
    .busy(busy), .finish(finish), .culled_cnt(culled_cnt)
  );

  typedef struct {
    int          due;
    logic [AW-1:0] a;
    logic [1:0]  t;
  } ev_t;

  logic [AW-1:0] fa [16];
  logic [AW-1:0] fb [16];
  logic [AW-1:0] fc [16];
  ev_t           sq[$], rq[$], pend[$];
  logic [AW+1:0] exp_iss[$];
  logic [TW-1:0] exp_tri[$];
  logic [AW-1:0] iss_log[$];
  int            cyc, rd_cnt, pops, fin_cnt, fin_cyc, en_cyc;
  int            checks, errors, exp_culled;
  int            shd_mode, ret_mode;
  int            perm [3];
  logic          rast_ready = 1'b1;
  logic          sv_stall, tv_stall;
  logic [AW+1:0] sv_hold, e;
  logic [TW-1:0] tv_hold, t;

  function automatic logic [VW-1:0] vdata(logic [AW-1:0] i);
    return {12'(i * 3 + 1), 12'(i ^ 20'h5A5),
            21'(i * 7 + 11), 24'((i * 13) ^ 24'hABCDEF)};
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_face(int i, int a, int b, int c);
    fa[i] = AW'(a);
    fb[i] = AW'(b);
    fc[i] = AW'(c);
  endtask

  task automatic job(int n, bit cull);
    exp_iss.delete();
    exp_tri.delete();
    iss_log.delete();
    rd_cnt = 0;
    pops = 0;
    fin_cnt = 0;
    exp_culled = 0;
    for (int i = 0; i < n; i++) begin
      if (cull && (fa[i] == fb[i] || fa[i] == fc[i] || fb[i] == fc[i]))
        exp_culled++;
      else begin
        exp_iss.push_back({2'd0, fa[i]});
        exp_iss.push_back({2'd1, fb[i]});
        exp_iss.push_back({2'd2, fc[i]});
        exp_tri.push_back({vdata(fa[i]), vdata(fb[i]), vdata(fc[i])});
      end
    end
    num_of_faces = FW'(n);
    cull_en = cull;
    enable = 1'b1;
    en_cyc = cyc;
    tick();
    enable = 1'b0;
  endtask

  task automatic wait_fin(string name, int budget);
    int k = 0;
    while (fin_cnt == 0 && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (fin_cnt == 0) begin
      errors++;
      $display("FAIL %s: finish not seen within %0d cycles", name, budget);
    end
    repeat (3) tick();
    chk({name, "_fin_once"}, fin_cnt, 1);
  endtask

  // Reactive models: SRAM, shader, rasterizer and the compare process
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (srst) begin
        vtx_valid = 1'b0;
        shd_ready = 1'b0;
        tri_ready = 1'b0;
        sv_stall = 1'b0;
        tv_stall = 1'b0;
      end else begin
        if (sram_rd_en) begin
          chk("sram_addr", sram_addr, rd_cnt);
          rd_cnt++;
          sq.push_back('{cyc + LAT, sram_addr, 2'd0});
        end
        face_v1 = '1;
        face_v2 = '1;
        face_v3 = '1;
        if (sq.size() > 0 && sq[0].due <= cyc) begin
          face_v1 = fa[sq[0].a[3:0]];
          face_v2 = fb[sq[0].a[3:0]];
          face_v3 = fc[sq[0].a[3:0]];
          void'(sq.pop_front());
        end
        if (sv_stall)
          chk("shd_hold", {shd_valid, shd_tag, shd_vidx}, {1'b1, sv_hold});
        shd_ready = (shd_mode == 0) || (cyc % 3 != 0);
        if (shd_valid && shd_ready) begin
          e = '1;
          if (exp_iss.size() > 0) e = exp_iss.pop_front();
          chk("shd_issue", {shd_tag, shd_vidx}, e);
          iss_log.push_back(shd_vidx);
          if (ret_mode == 1) begin
            rq.push_back('{cyc + 1, shd_vidx, shd_tag});
          end else begin
            pend.push_back('{0, shd_vidx, shd_tag});
            if (pend.size() == 3) begin
              for (int i = 0; i < 3; i++)
                rq.push_back('{cyc + 2 + i, pend[perm[i]].a, pend[perm[i]].t});
              pend.delete();
            end
          end
        end
        sv_stall = shd_valid && !shd_ready;
        sv_hold = {shd_tag, shd_vidx};
        vtx_valid = 1'b0;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
          vtx_valid = 1'b1;
          vtx_tag = rq[0].t;
          vtx_data = vdata(rq[0].a);
          void'(rq.pop_front());
        end
        if (tv_stall)
          chk("tri_hold", {tri_valid, tri_data}, {1'b1, tv_hold});
        tri_ready = rast_ready;
        if (tri_valid && tri_ready) begin
          t = '1;
          if (exp_tri.size() > 0) t = exp_tri.pop_front();
          chk("tri_data", tri_data, t);
          pops++;
        end
        tv_stall = tri_valid && !tri_ready;
        tv_hold = tri_data;
        if (finish) begin
          fin_cnt++;
          fin_cyc = cyc;
          chk("fin_drained", exp_tri.size(), 0);
          chk("fin_tri_valid", tri_valid, 0);
          chk("fin_busy", busy, 0);
          chk("fin_culled", culled_cnt, exp_culled);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    perm = '{0, 1, 2};
    shd_mode = 0;
    ret_mode = 0;
    repeat (3) tick();
    chk("reset_outs", {sram_rd_en, sram_addr, shd_valid, shd_vidx, shd_tag,
                       tri_valid, busy, finish, culled_cnt}, 0);
    chk("reset_tri_data", tri_data, 0);
    srst = 1'b0;
    tick();

    // single face, in-order returns
    set_face(0, 5, 9, 2);
    job(1, 0);
    chk("t1_busy", busy, 1);
    wait_fin("t1", 500);
    chk("t1_iss", iss_log.size() == 3 ?
        {iss_log[0], iss_log[1], iss_log[2]} : '0,
        {20'd5, 20'd9, 20'd2});
    chk("t1_pops", pops, 1);
    chk("t1_culled", culled_cnt, 0);

    // buffer fills with the rasterizer stalled
    for (int i = 0; i < 8; i++) set_face(i, 3 * i + 1, 3 * i + 2, 3 * i + 3);
    rast_ready = 1'b0;
    job(8, 0);
    repeat (300) tick();
    chk("t2_reads_stalled", rd_cnt, 4);
    chk("t2_no_pops", pops, 0);
    chk("t2_tri_valid", tri_valid, 1);
    chk("t2_busy", busy, 1);
    num_of_faces = FW'(3);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    num_of_faces = FW'(8);
    rast_ready = 1'b1;
    wait_fin("t2", 2000);
    chk("t2_pops", pops, 8);
    chk("t2_reads", rd_cnt, 8);

    // out-of-order returns and a throttled shader
    set_face(0, 10, 20, 30);
    set_face(1, 40, 50, 60);
    perm = '{2, 0, 1};
    shd_mode = 1;
    job(2, 0);
    wait_fin("t3", 1000);
    chk("t3_pops", pops, 2);
    perm = '{0, 1, 2};
    shd_mode = 0;

    // culling
    set_face(0, 1, 1, 3);
    set_face(1, 4, 5, 6);
    set_face(2, 7, 8, 7);
    set_face(3, 9, 2, 2);
    job(2, 1);
    wait_fin("t4a", 1000);
    chk("t4a_pops", pops, 1);
    chk("t4a_culled", culled_cnt, 1);
    job(4, 1);
    wait_fin("t4b", 1000);
    chk("t4b_pops", pops, 1);
    chk("t4b_culled", culled_cnt, 3);
    job(2, 0);
    wait_fin("t4c", 1000);
    chk("t4c_pops", pops, 2);
    chk("t4c_culled", culled_cnt, 0);

    // returns arriving while the face is still being issued
    set_face(0, 100, 200, 300);
    set_face(1, 7, 7, 8);
    ret_mode = 1;
    job(2, 0);
    wait_fin("t5", 1000);
    chk("t5_pops", pops, 2);
    ret_mode = 0;

    // empty job
    job(0, 0);
    wait_fin("t6", 50);
    chk("t6_fin_lat", fin_cyc - en_cyc, 2);
    chk("t6_reads", rd_cnt, 0);

    // reset in the middle of collecting the third face
    set_face(0, 1, 2, 3);
    set_face(1, 4, 5, 6);
    set_face(2, 7, 8, 9);
    rast_ready = 1'b0;
    job(3, 0);
    for (int k = 0; k < 500 && iss_log.size() < 9; k++) tick();
    chk("t7_issued", iss_log.size(), 9);
    tick();
    chk("t7_buffered", tri_valid, 1);
    srst = 1'b1;
    sq.delete();
    rq.delete();
    pend.delete();
    exp_iss.delete();
    exp_tri.delete();
    tick();
    chk("t7_rst_outs", {sram_rd_en, sram_addr, shd_valid, shd_vidx, shd_tag,
                        tri_valid, busy, finish, culled_cnt}, 0);
    chk("t7_rst_tri_data", tri_data, 0);
    srst = 1'b0;
    rast_ready = 1'b1;
    set_face(0, 21, 22, 23);
    tick();
    job(1, 0);
    wait_fin("t7", 500);
    chk("t7_pops", pops, 1);
    chk("t7_first_vidx", iss_log.size() > 0 ? iss_log[0] : '0, 21);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
